// File: rtl/coin_accumulator.sv
// coin_accumulator
// Credit accumulator for a coin-operated vending front end. Rising edges on
// the three debounced coin lines add 1, 2 or 5 units of credit (capped at
// 99). A purchase request subtracts the price when enough credit is present.
// A refund request pays back all credit one unit at a time, as one
// change_pulse high cycle followed by one low cycle per unit.
//
// Ports
//   clk           system clock, all state changes on its rising edge
//   reset         synchronous, active-high
//   COIN1/2/5     debounced coin levels; each rising edge is one coin
//   buy_req       purchase request, with price (7-bit unsigned units)
//   refund_req    request return of all credit
//   credit        current credit 0..99, with BCD digits credit_tens/ones
//   buy_ok        one-cycle pulse, purchase accepted
//   buy_fail      one-cycle pulse, purchase refused
//   coin_reject   one-cycle pulse, a coin edge was not credited
//   change_pulse  high for one cycle per returned unit
//   refund_done   one-cycle pulse when a refund completes
//   busy          high while a refund is being paid out
module coin_accumulator (
  input  logic       clk,
  input  logic       reset,
  input  logic       COIN1,
  input  logic       COIN2,
  input  logic       COIN5,
  input  logic       buy_req,
  input  logic [6:0] price,
  input  logic       refund_req,
  output logic [6:0] credit,
  output logic [3:0] credit_tens,
  output logic [3:0] credit_ones,
  output logic       buy_ok,
  output logic       buy_fail,
  output logic       coin_reject,
  output logic       change_pulse,
  output logic       refund_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PAY_HI = 2'd1,
    PAY_LO = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [6:0] credit_next;
  logic       buy_ok_next;
  logic       buy_fail_next;
  logic       coin_reject_next;
  logic       refund_done_next;

  logic       coin1_prev;
  logic       coin2_prev;
  logic       coin5_prev;
  logic       edge1;
  logic       edge2;
  logic       edge5;
  logic       any_edge;
  logic       multi_edge;
  logic [6:0] coin_value;
  logic [7:0] coin_sum;

  // Edge detection and coin valuation. Only the most valuable coin of a
  // simultaneous group is considered; the sum is one bit wider than credit
  // so the cap at 99 can be tested without wrap-around.
  always_comb begin
    edge1      = COIN1 & ~coin1_prev;
    edge2      = COIN2 & ~coin2_prev;
    edge5      = COIN5 & ~coin5_prev;
    any_edge   = edge1 | edge2 | edge5;
    multi_edge = (edge5 & (edge2 | edge1)) | (edge2 & edge1);
    coin_value = 7'd0;
    if (edge5) begin
      coin_value = 7'd5;
    end else if (edge2) begin
      coin_value = 7'd2;
    end else if (edge1) begin
      coin_value = 7'd1;
    end
    coin_sum = {1'b0, credit} + {1'b0, coin_value};
  end

  // Next-state and next-output logic. In IDLE a purchase outranks a refund,
  // which outranks coins; any coin edge that loses that arbitration, or that
  // arrives during a refund, is rejected. During a refund every unit takes a
  // PAY_HI cycle (the pulse) and a PAY_LO cycle (the gap); credit drops on
  // the PAY_HI -> PAY_LO edge, so PAY_LO sees the already-reduced value.
  always_comb begin
    state_next       = state;
    credit_next      = credit;
    buy_ok_next      = 1'b0;
    buy_fail_next    = 1'b0;
    coin_reject_next = 1'b0;
    refund_done_next = 1'b0;
    case (state)
      IDLE: begin
        if (buy_req) begin
          coin_reject_next = any_edge;
          if (price <= credit) begin
            credit_next = credit - price;
            buy_ok_next = 1'b1;
          end else begin
            buy_fail_next = 1'b1;
          end
        end else if (refund_req) begin
          coin_reject_next = any_edge;
          if (credit != 7'd0) begin
            state_next = PAY_HI;
          end else begin
            refund_done_next = 1'b1;
          end
        end else if (any_edge) begin
          if (coin_sum > 8'd99) begin
            coin_reject_next = 1'b1;
          end else begin
            credit_next      = coin_sum[6:0];
            coin_reject_next = multi_edge;
          end
        end
      end
      PAY_HI: begin
        state_next       = PAY_LO;
        credit_next      = credit - 7'd1;
        buy_fail_next    = buy_req;
        coin_reject_next = any_edge;
      end
      PAY_LO: begin
        buy_fail_next    = buy_req;
        coin_reject_next = any_edge;
        if (credit != 7'd0) begin
          state_next = PAY_HI;
        end else begin
          state_next       = IDLE;
          refund_done_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, credit and pulse registers. Reset loads the previous-coin
  // registers with the live coin levels so a coin held through reset does
  // not look like a fresh edge afterwards; it also aborts a refund silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      credit      <= 7'd0;
      buy_ok      <= 1'b0;
      buy_fail    <= 1'b0;
      coin_reject <= 1'b0;
      refund_done <= 1'b0;
    end else begin
      state       <= state_next;
      credit      <= credit_next;
      buy_ok      <= buy_ok_next;
      buy_fail    <= buy_fail_next;
      coin_reject <= coin_reject_next;
      refund_done <= refund_done_next;
    end
    coin1_prev <= COIN1;
    coin2_prev <= COIN2;
    coin5_prev <= COIN5;
  end

  // Outputs decoded directly from registers, so they change with the state.
  always_comb begin
    change_pulse = (state == PAY_HI);
    busy         = (state != IDLE);
    credit_tens  = 4'(credit / 7'd10);
    credit_ones  = 4'(credit % 7'd10);
  end

endmodule

// File: tb/tb_coin_accumulator.sv
// tb_coin_accumulator
// Drives coin_accumulator with directed scenarios followed by random traffic.
// A behavioural model tracks credit as an integer and describes a refund as
// a timeline: with c units owed, the refund lasts 2*c cycles, the pulse is
// high on even cycle offsets, and the credit shown at offset t is c-(t+1)/2.
module tb_coin_accumulator;

  logic       clk = 1'b0;
  logic       reset;
  logic       COIN1, COIN2, COIN5;
  logic       buy_req;
  logic [6:0] price;
  logic       refund_req;
  logic [6:0] credit;
  logic [3:0] credit_tens, credit_ones;
  logic       buy_ok, buy_fail, coin_reject, change_pulse, refund_done, busy;

  int checks = 0;
  int errors = 0;

  // model state
  int m_credit = 0;
  bit m_active = 0;
  int m_c = 0;
  int m_t = 0;
  bit m_prev1 = 0, m_prev2 = 0, m_prev5 = 0;
  bit exp_ok, exp_fail, exp_reject, exp_done;

  coin_accumulator dut (
    .clk          (clk),
    .reset        (reset),
    .COIN1        (COIN1),
    .COIN2        (COIN2),
    .COIN5        (COIN5),
    .buy_req      (buy_req),
    .price        (price),
    .refund_req   (refund_req),
    .credit       (credit),
    .credit_tens  (credit_tens),
    .credit_ones  (credit_ones),
    .buy_ok       (buy_ok),
    .buy_fail     (buy_fail),
    .coin_reject  (coin_reject),
    .change_pulse (change_pulse),
    .refund_done  (refund_done),
    .busy         (busy)
  );

  // 10 time-unit clock
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports any mismatch.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance the model by one clock edge using the inputs being applied.
  task automatic modelStep(input bit c1, input bit c2, input bit c5, input bit b,
                           input int p, input bit r, input bit rst);
    bit e1, e2, e5;
    int n, v;
    exp_ok = 0; exp_fail = 0; exp_reject = 0; exp_done = 0;
    e1 = c1 && !m_prev1;
    e2 = c2 && !m_prev2;
    e5 = c5 && !m_prev5;
    n  = int'(e1) + int'(e2) + int'(e5);
    v  = e5 ? 5 : (e2 ? 2 : (e1 ? 1 : 0));
    if (rst) begin
      m_credit = 0;
      m_active = 0;
    end else if (m_active) begin
      if (n > 0) exp_reject = 1;
      if (b) exp_fail = 1;
      m_t++;
      if (m_t == 2 * m_c) begin
        m_active = 0;
        m_credit = 0;
        exp_done = 1;
      end else begin
        m_credit = m_c - (m_t + 1) / 2;
      end
    end else if (b) begin
      if (n > 0) exp_reject = 1;
      if (p <= m_credit) begin
        m_credit -= p;
        exp_ok = 1;
      end else begin
        exp_fail = 1;
      end
    end else if (r) begin
      if (n > 0) exp_reject = 1;
      if (m_credit > 0) begin
        m_active = 1;
        m_c = m_credit;
        m_t = 0;
      end else begin
        exp_done = 1;
      end
    end else if (n > 0) begin
      if (m_credit + v > 99 || n > 1) exp_reject = 1;
      if (m_credit + v <= 99) m_credit += v;
    end
    m_prev1 = c1;
    m_prev2 = c2;
    m_prev5 = c5;
  endtask

  // Apply one cycle of inputs, then compare every output with the model.
  task automatic applyStimulus(input bit c1, input bit c2, input bit c5, input bit b,
                               input logic [6:0] p, input bit r, input bit rst);
    @(negedge clk);
    COIN1 = c1; COIN2 = c2; COIN5 = c5;
    buy_req = b; price = p; refund_req = r; reset = rst;
    modelStep(c1, c2, c5, b, int'(p), r, rst);
    @(posedge clk);
    #1;
    checkOutput("credit", int'(credit), m_credit);
    checkOutput("credit_tens", int'(credit_tens), m_credit / 10);
    checkOutput("credit_ones", int'(credit_ones), m_credit % 10);
    checkOutput("buy_ok", int'(buy_ok), int'(exp_ok));
    checkOutput("buy_fail", int'(buy_fail), int'(exp_fail));
    checkOutput("coin_reject", int'(coin_reject), int'(exp_reject));
    checkOutput("change_pulse", int'(change_pulse), int'(m_active && (m_t % 2 == 0)));
    checkOutput("refund_done", int'(refund_done), int'(exp_done));
    checkOutput("busy", int'(busy), int'(m_active));
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 7'd0, 0, 0);
  endtask

  // One coin: raise the selected line for a cycle, then drop it.
  task automatic coinPulse(input int value);
    applyStimulus(value == 1, value == 2, value == 5, 0, 7'd0, 0, 0);
    idleCycle();
  endtask

  initial begin
    bit ch [7] = '{1, 0, 1, 0, 1, 0, 0};
    int cr [7] = '{3, 2, 2, 1, 1, 0, 0};
    bit dn [7] = '{0, 0, 0, 0, 0, 0, 1};
    bit bs [7] = '{1, 1, 1, 1, 1, 1, 0};
    bit c1, c2, c5, b, r, rst;
    logic [6:0] p;

    COIN1 = 0; COIN2 = 0; COIN5 = 0;
    buy_req = 0; price = 0; refund_req = 0; reset = 1;

    // reset with COIN5 held high; no credit once reset is released
    applyStimulus(0, 0, 1, 0, 7'd0, 0, 1);
    applyStimulus(0, 0, 1, 0, 7'd0, 0, 1);
    checkOutput("reset_credit", int'(credit), 0);
    checkOutput("reset_busy", int'(busy), 0);
    applyStimulus(0, 0, 1, 0, 7'd0, 0, 0);
    checkOutput("held_coin_credit", int'(credit), 0);
    idleCycle();

    // 5 + 2 + 1 = 8
    coinPulse(5);
    coinPulse(2);
    coinPulse(1);
    checkOutput("sum_credit", int'(credit), 8);
    checkOutput("sum_tens", int'(credit_tens), 0);
    checkOutput("sum_ones", int'(credit_ones), 8);

    // buy 7 succeeds, buy 2 fails
    applyStimulus(0, 0, 0, 1, 7'd7, 0, 0);
    checkOutput("buy7_ok", int'(buy_ok), 1);
    checkOutput("buy7_credit", int'(credit), 1);
    applyStimulus(0, 0, 0, 1, 7'd2, 0, 0);
    checkOutput("buy2_fail", int'(buy_fail), 1);
    checkOutput("buy2_credit", int'(credit), 1);

    // credit 3, refund with a coin arriving while busy
    coinPulse(2);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(k == 2, 0, 0, 0, 7'd0, k == 0, 0);
      checkOutput("refund_change", int'(change_pulse), int'(ch[k]));
      checkOutput("refund_credit", int'(credit), cr[k]);
      checkOutput("refund_done", int'(refund_done), int'(dn[k]));
      checkOutput("refund_busy", int'(busy), int'(bs[k]));
      if (k == 2) checkOutput("busy_coin_reject", int'(coin_reject), 1);
    end

    // climb to 97, then overflow and cap cases
    for (int k = 0; k < 19; k++) coinPulse(5);
    coinPulse(2);
    checkOutput("credit97", int'(credit), 97);
    applyStimulus(0, 0, 1, 0, 7'd0, 0, 0);
    checkOutput("over_reject", int'(coin_reject), 1);
    checkOutput("over_credit", int'(credit), 97);
    idleCycle();
    applyStimulus(0, 1, 0, 0, 7'd0, 0, 0);
    checkOutput("cap_credit", int'(credit), 99);
    checkOutput("cap_tens", int'(credit_tens), 9);
    checkOutput("cap_ones", int'(credit_ones), 9);
    idleCycle();
    coinPulse(1);

    // price 0 accepted, full purchase, simultaneous coins
    applyStimulus(0, 0, 0, 1, 7'd0, 0, 0);
    checkOutput("price0_ok", int'(buy_ok), 1);
    applyStimulus(0, 0, 0, 1, 7'd99, 0, 0);
    checkOutput("buy99_credit", int'(credit), 0);
    applyStimulus(1, 0, 1, 0, 7'd0, 0, 0);
    checkOutput("multi_credit", int'(credit), 5);
    checkOutput("multi_reject", int'(coin_reject), 1);
    idleCycle();

    // refund aborted by reset
    applyStimulus(0, 0, 0, 0, 7'd0, 1, 0);
    idleCycle();
    idleCycle();
    applyStimulus(0, 0, 0, 0, 7'd0, 0, 1);
    checkOutput("abort_credit", int'(credit), 0);
    checkOutput("abort_change", int'(change_pulse), 0);
    checkOutput("abort_busy", int'(busy), 0);
    idleCycle();
    checkOutput("abort_no_done", int'(refund_done), 0);

    // refund with zero credit completes at once
    applyStimulus(0, 0, 0, 0, 7'd0, 1, 0);
    checkOutput("zero_refund_done", int'(refund_done), 1);

    // random traffic
    c1 = 0; c2 = 0; c5 = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) c1 = ~c1;
      if ($urandom_range(0, 3) == 0) c2 = ~c2;
      if ($urandom_range(0, 3) == 0) c5 = ~c5;
      b   = ($urandom_range(0, 15) == 0);
      p   = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                        : 7'($urandom_range(0, 20));
      r   = ($urandom_range(0, 31) == 0);
      rst = ($urandom_range(0, 199) == 0);
      applyStimulus(c1, c2, c5, b, p, r, rst);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coin_accumulator.md
COIN_ACCUMULATOR -- requirements
Module: coin_accumulator

Interface
REQ-001 SHALL have port clk, input, 1, single system clock (divided clock domain); all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port COIN1, input, 1, debounced level; each rising edge is one coin worth 1 unit.
REQ-004 SHALL have port COIN2, input, 1, debounced level; each rising edge is one coin worth 2 units.
REQ-005 SHALL have port COIN5, input, 1, debounced level; each rising edge is one coin worth 5 units.
REQ-006 SHALL have port buy_req, input, 1, purchase request, sampled each cycle.
REQ-007 SHALL have port price, input, 7, unsigned purchase price in units, valid with buy_req.
REQ-008 SHALL have port refund_req, input, 1, request return of all credit, sampled each cycle.
REQ-009 SHALL have port credit, output, 7, current credit in units (0..99).
REQ-010 SHALL have port credit_tens, output, 4, BCD tens digit of credit.
REQ-011 SHALL have port credit_ones, output, 4, BCD ones digit of credit.
REQ-012 SHALL have port buy_ok, output, 1, one-cycle pulse: purchase accepted.
REQ-013 SHALL have port buy_fail, output, 1, one-cycle pulse: purchase refused.
REQ-014 SHALL have port coin_reject, output, 1, one-cycle pulse: coin edge not credited.
REQ-015 SHALL have port change_pulse, output, 1, one high cycle per returned unit.
REQ-016 SHALL have port refund_done, output, 1, one-cycle pulse: refund complete.
REQ-017 SHALL have port busy, output, 1, high while refund in progress.

Function
REQ-018 SHALL detect coin edges as level=1 with previous registered level=0, one previous-level register per coin input.
REQ-019 SHALL register all outputs; credit updates, buy_ok, buy_fail and coin_reject appear 1 cycle after the triggering edge.
REQ-020 SHALL implement states IDLE, PAY_HI, PAY_LO; change_pulse = (state==PAY_HI); busy = (state!=IDLE).
REQ-021 In IDLE with buy_req=1: if price<=credit, credit -= price and buy_ok pulses; else credit unchanged and buy_fail pulses; price=0 is accepted.
REQ-022 In IDLE with refund_req=1 and buy_req=0: if credit>0 go to PAY_HI; if credit=0 stay IDLE and pulse refund_done next cycle.
REQ-023 PAY_HI SHALL always go to PAY_LO, decrementing credit by 1 on that edge.
REQ-024 PAY_LO SHALL go to PAY_HI if credit>0, else to IDLE with refund_done high for the first IDLE cycle.
REQ-025 Priority in IDLE SHALL be buy_req > refund_req > coin edges; coin edges in a cycle with buy_req or refund_req SHALL be rejected.
REQ-026 With several simultaneous coin edges, only the highest value (COIN5>COIN2>COIN1) SHALL be considered; the others are lost and coin_reject pulses once.
REQ-027 A coin whose addition would make credit exceed 99 SHALL be rejected, credit unchanged.
REQ-028 Any coin edge in PAY_HI or PAY_LO SHALL be rejected; buy_req while busy SHALL give buy_fail; refund_req while busy SHALL be ignored.
REQ-029 credit_tens/credit_ones SHALL always equal the BCD form of credit, in the same cycle.

Reset
REQ-030 reset=1 at a clock edge SHALL force state IDLE, credit 0, all pulse outputs 0, busy 0, and previous-coin registers to the current input levels, so that a coin held high through reset is not counted.
REQ-031 Reset during PAY_HI/PAY_LO SHALL abort the refund with no refund_done; remaining credit is lost.

Verification
REQ-032 Reset, then COIN5 edge, COIN2 edge, COIN1 edge -> credit 8, tens 0, ones 8, no coin_reject.
REQ-033 Credit 8, buy_req with price=7 -> buy_ok 1 cycle, credit 1; then price=2 -> buy_fail, credit stays 1.
REQ-034 Credit 3, refund_req at edge n -> change_pulse high at n+1, n+3, n+5; credit 2, 1, 0; refund_done at n+7; busy low from n+7.
REQ-035 Credit 97, COIN5 edge -> coin_reject, credit 97; COIN2 edge -> credit 99, BCD 9/9.
REQ-036 COIN5 and COIN1 rising on the same edge -> credit +5, coin_reject 1 cycle; coin edge while busy -> coin_reject, refund sequence unaffected.
REQ-037 Reset asserted mid-refund -> IDLE, credit 0, change_pulse 0, no refund_done.
